mem_bus_seq: RTL and testbench
==============================

# mem_bus_seq

Synchronous sequencer for the fixed/erasable memory data bus. It turns single-word read/write requests into chip-enable, output-enable and write-enable strobes for the memory array. It also drives the active-low output enables of the two 8-bit lanes of tri-state bus buffers that carry write data onto the shared bus. It is the stage directly upstream of the bus buffers and guarantees that buffers and memory never drive the bus at the same time.

## Interface
Parameters:
- AW, 12, memory address width
- ACCESS_CYCLES, 3, length of the strobe-active phase in clocks; legal range 2–15

Ports:
- CLK  input  1  system clock; all state changes on rising edge
- RESET  input  1  synchronous, active-high reset
- REQ  input  1  request strobe; sampled only in IDLE
- WR  input  1  1 = write, 0 = read; sampled with REQ
- ADDR  input  AW  word address; sampled with REQ
- WDATA  input  16  write data; sampled with REQ
- LANE_EN  input  2  write lane enables ([0] = low byte, [1] = high byte); ignored for reads
- MDATA_IN  input  16  bus data returned from memory
- BUSY  output  1  1 whenever state ≠ IDLE
- DONE  output  1  one-cycle completion pulse
- RDATA_Q  output  16  last captured read word
- MADDR  output  AW  registered memory address
- MCE_  output  1  memory chip enable, active low
- MOE_  output  1  memory output enable, active low
- MWE_  output  1  memory write enable, active low
- BUF_OEA_  output  1  low-lane buffer enable, active low
- BUF_OEB_  output  1  high-lane buffer enable, active low
- MDATA_OUT  output  16  registered write data, feeding the buffer inputs

## Operation
- All outputs are registered.
- Reset values:
  - Active-low strobes (MCE_, MOE_, MWE_, BUF_OEA_, BUF_OEB_) = 1.
  - BUSY = 0, DONE = 0.
  - RDATA_Q, MADDR, MDATA_OUT = 0.
  - State = IDLE, access counter = 0.
- States: IDLE → SETUP → ACCESS → RECOVER → IDLE.
- **IDLE**
  - All strobes are high.
  - REQ = 1 latches ADDR→MADDR, WDATA→MDATA_OUT, WR and LANE_EN. Next state is SETUP.
  - REQ = 0 stays in IDLE.
- **SETUP** (1 cycle)
  - MCE_ = 0; all other strobes high.
  - The address is stable before any enable asserts.
- **ACCESS** (ACCESS_CYCLES cycles, counted by an internal down-counter)
  - MCE_ = 0 throughout.
  - Read:
    - MOE_ = 0 throughout.
    - On the edge that ends the last ACCESS cycle, MDATA_IN → RDATA_Q.
  - Write:
    - BUF_OEA_ = ~LANE_EN[0] and BUF_OEB_ = ~LANE_EN[1], throughout.
    - MWE_ = 0 in every ACCESS cycle except the last, which gives one cycle of data hold.
    - With LANE_EN = 00 the strobes still sequence, but no buffer is enabled.
- **RECOVER** (1 cycle)
  - All strobes are high.
  - DONE = 1.
  - Next state is IDLE.
- Contention rule: MOE_ = 0 and (BUF_OEA_ = 0 or BUF_OEB_ = 0) must never hold in the same cycle. SETUP and RECOVER guarantee at least one all-released cycle between transactions.
- REQ asserted while BUSY = 1 is ignored. There is no queueing, and the latched fields do not change.
- RDATA_Q holds its value until the next read completes; writes do not alter it.
- RESET asserted mid-transaction:
  - At the next edge all outputs take their reset values and the state returns to IDLE.
  - The aborted transaction produces no DONE.

## Timing
- E0 is the edge that samples REQ = 1 in IDLE. With N = ACCESS_CYCLES:
  - After E0: SETUP; BUSY = 1, MCE_ = 0.
  - After E1 … E(N): ACCESS cycles 1 … N.
  - At E(N+1): RDATA_Q is captured (reads only). After E(N+1): RECOVER, DONE = 1.
  - After E(N+2): IDLE, BUSY = 0, DONE = 0.
- The earliest next acceptance is E(N+3). Back-to-back period is therefore N + 3 clocks (6 clocks at the default).
- The read result is valid on RDATA_Q in the same cycle DONE = 1, and stays valid afterward.
- MADDR and MDATA_OUT are stable from the cycle after E0 until the next accepted request.

## Test plan
- Reset then idle: hold RESET for 2 cycles, then REQ = 0 for 10 cycles → all strobes 1, BUSY = 0, DONE = 0, RDATA_Q = 0000.
- Read, N = 3:
  - Stimulus: REQ pulse with WR = 0, ADDR = 0x2A5; MDATA_IN = 0xBEEF held during ACCESS.
  - MCE_ low for cycles 1–4 after E0.
  - MOE_ low for cycles 2–4.
  - DONE high in cycle 5, with RDATA_Q = 0xBEEF.
  - BUSY low from cycle 6.
- Write, LANE_EN = 10:
  - Stimulus: WDATA = 0x1234.
  - BUF_OEB_ low for cycles 2–4; BUF_OEA_ stays 1.
  - MWE_ low for cycles 2–3 only.
  - MDATA_OUT = 0x1234.
  - RDATA_Q unchanged.
- REQ held high continuously with alternating read/write:
  - Transactions accepted exactly every 6 cycles.
  - Requests during BUSY are ignored.
  - The contention checker (MOE_ low with any BUF_OE*_ low) never fires.
- Reset mid-access:
  - Assert RESET in ACCESS cycle 2 of a write.
  - Next cycle: all strobes 1, BUSY = 0.
  - No DONE pulse.
  - A new read is then accepted normally.
- Parameter sweep: N = 2 and N = 15 → period = N + 3; write MWE_ low for N − 1 cycles; read capture on the edge that ends the last ACCESS cycle.

Source files
------------

// File: rtl/mem_bus_seq.sv
// Memory bus sequencer: turns single-word read/write requests into registered
// chip/output/write enables plus per-lane write-buffer enables, never letting both drive the bus.
module mem_bus_seq #(
  parameter int AW            = 12,
  parameter int ACCESS_CYCLES = 3
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          REQ,
  input  logic          WR,
  input  logic [AW-1:0] ADDR,
  input  logic [15:0]   WDATA,
  input  logic [1:0]    LANE_EN,
  input  logic [15:0]   MDATA_IN,
  output logic          BUSY,
  output logic          DONE,
  output logic [15:0]   RDATA_Q,
  output logic [AW-1:0] MADDR,
  output logic          MCE_,
  output logic          MOE_,
  output logic          MWE_,
  output logic          BUF_OEA_,
  output logic          BUF_OEB_,
  output logic [15:0]   MDATA_OUT
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RECOVER} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

  state_t        state, state_nx;
  logic [3:0]    cnt, cnt_nx;
  logic          wr_q, wr_nx;
  logic [1:0]    lane_q, lane_nx;
  logic [15:0]   rdata_nx, mdata_out_nx;
  logic [AW-1:0] maddr_nx;
  logic          busy_nx, done_nx, in_access_nx;
  logic          mce_nx, moe_nx, mwe_nx, oea_nx, oeb_nx;

  // Strobes are derived from the next state so every output leaves a flop;
  // the down-counter reaching zero marks the last ACCESS cycle (data hold for writes).
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    wr_nx        = wr_q;
    lane_nx      = lane_q;
    rdata_nx     = RDATA_Q;
    maddr_nx     = MADDR;
    mdata_out_nx = MDATA_OUT;

    case (state)
      IDLE: begin
        if (REQ) begin
          state_nx     = SETUP;
          wr_nx        = WR;
          lane_nx      = LANE_EN;
          maddr_nx     = ADDR;
          mdata_out_nx = WDATA;
        end
      end
      SETUP: begin
        state_nx = ACCESS;
        cnt_nx   = CNT_LOAD;
      end
      ACCESS: begin
        if (cnt == 4'd0) begin
          state_nx = RECOVER;
          if (!wr_q) rdata_nx = MDATA_IN;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      RECOVER: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    // Read and write enables are mutually exclusive through wr_nx, so the
    // memory and the buffers can never drive the bus in the same cycle.
    in_access_nx = (state_nx == ACCESS);
    busy_nx      = (state_nx != IDLE);
    done_nx      = (state_nx == RECOVER);
    mce_nx       = !((state_nx == SETUP) || in_access_nx);
    moe_nx       = !(in_access_nx && !wr_nx);
    mwe_nx       = !(in_access_nx && wr_nx && (cnt_nx != 4'd0));
    oea_nx       = !(in_access_nx && wr_nx && lane_nx[0]);
    oeb_nx       = !(in_access_nx && wr_nx && lane_nx[1]);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      wr_q      <= 1'b0;
      lane_q    <= 2'b00;
      RDATA_Q   <= 16'h0000;
      MADDR     <= '0;
      MDATA_OUT <= 16'h0000;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      MCE_      <= 1'b1;
      MOE_      <= 1'b1;
      MWE_      <= 1'b1;
      BUF_OEA_  <= 1'b1;
      BUF_OEB_  <= 1'b1;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      wr_q      <= wr_nx;
      lane_q    <= lane_nx;
      RDATA_Q   <= rdata_nx;
      MADDR     <= maddr_nx;
      MDATA_OUT <= mdata_out_nx;
      BUSY      <= busy_nx;
      DONE      <= done_nx;
      MCE_      <= mce_nx;
      MOE_      <= moe_nx;
      MWE_      <= mwe_nx;
      BUF_OEA_  <= oea_nx;
      BUF_OEB_  <= oeb_nx;
    end
  end

endmodule

// File: tb/tb_mem_bus_seq.sv
// Bench for mem_bus_seq: three instances (N = 3, 2, 15) driven by directed transactions;
// a per-instance scoreboard checks strobe timing and data whenever DONE appears.
module tb_mem_bus_seq;

  localparam int AW    = 12;
  localparam int NS[3] = '{3, 2, 15};

  typedef struct {
    int          e0;
    logic        wr;
    logic [11:0] addr;
    logic [15:0] wdata;
    logic [1:0]  lane;
    logic [15:0] rdata;
  } item_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  logic          req       [3];
  logic          wr        [3];
  logic [AW-1:0] addr      [3];
  logic [15:0]   wdata     [3];
  logic [1:0]    lane_en   [3];
  logic [15:0]   mdata_in  [3];
  logic          busy      [3];
  logic          done      [3];
  logic [15:0]   rdata_q   [3];
  logic [AW-1:0] maddr     [3];
  logic          mce_l     [3];
  logic          moe_l     [3];
  logic          mwe_l     [3];
  logic          oea_l     [3];
  logic          oeb_l     [3];
  logic [15:0]   mdata_out [3];
  logic [15:0]   last_read [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input int d,
                              input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s dut%0d (N=%0d): got 0x%0h, want 0x%0h", name, d, NS[d], act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : mon
    mem_bus_seq #(.AW(AW), .ACCESS_CYCLES(NS[g])) dut (
      .CLK      (clk),
      .RESET    (reset),
      .REQ      (req[g]),
      .WR       (wr[g]),
      .ADDR     (addr[g]),
      .WDATA    (wdata[g]),
      .LANE_EN  (lane_en[g]),
      .MDATA_IN (mdata_in[g]),
      .BUSY     (busy[g]),
      .DONE     (done[g]),
      .RDATA_Q  (rdata_q[g]),
      .MADDR    (maddr[g]),
      .MCE_     (mce_l[g]),
      .MOE_     (moe_l[g]),
      .MWE_     (mwe_l[g]),
      .BUF_OEA_ (oea_l[g]),
      .BUF_OEB_ (oeb_l[g]),
      .MDATA_OUT(mdata_out[g])
    );

    item_t sbq[$];
    int    n_mce, n_moe, n_mwe, n_oea, n_oeb;
    int    f_mce, f_moe, f_mwe;
    bit    clash;

    // Strobe activity is tallied per transaction and judged when DONE pops the scoreboard.
    always @(negedge clk) begin
      item_t it;
      int    n;
      n = NS[g];
      if (sbq.size() == 0) begin
        if (done[g]) check_output("spurious_done", g, 32'(done[g]), 32'd0);
        n_mce = 0; n_moe = 0; n_mwe = 0; n_oea = 0; n_oeb = 0;
        f_mce = -1; f_moe = -1; f_mwe = -1; clash = 1'b0;
      end else begin
        if (!mce_l[g]) begin n_mce++; if (f_mce < 0) f_mce = cyc; end
        if (!moe_l[g]) begin n_moe++; if (f_moe < 0) f_moe = cyc; end
        if (!mwe_l[g]) begin n_mwe++; if (f_mwe < 0) f_mwe = cyc; end
        if (!oea_l[g]) n_oea++;
        if (!oeb_l[g]) n_oeb++;
        if (!moe_l[g] && (!oea_l[g] || !oeb_l[g])) clash = 1'b1;
        if (done[g]) begin
          it = sbq.pop_front();
          check_output("done_cycle", g, 32'(cyc - it.e0), 32'(n + 2));
          check_output("busy_at_done", g, 32'(busy[g]), 32'd1);
          check_output("rdata_q", g, 32'(rdata_q[g]), 32'(it.rdata));
          check_output("maddr", g, 32'(maddr[g]), 32'(it.addr));
          check_output("mdata_out", g, 32'(mdata_out[g]), 32'(it.wdata));
          check_output("mce_cycles", g, 32'(n_mce), 32'(n + 1));
          check_output("mce_first", g, 32'(f_mce - it.e0), 32'd1);
          check_output("moe_cycles", g, 32'(n_moe), it.wr ? 32'd0 : 32'(n));
          check_output("mwe_cycles", g, 32'(n_mwe), it.wr ? 32'(n - 1) : 32'd0);
          check_output("oea_cycles", g, 32'(n_oea), (it.wr && it.lane[0]) ? 32'(n) : 32'd0);
          check_output("oeb_cycles", g, 32'(n_oeb), (it.wr && it.lane[1]) ? 32'(n) : 32'd0);
          check_output("contention", g, 32'(clash), 32'd0);
          if (!it.wr) check_output("moe_first", g, 32'(f_moe - it.e0), 32'd2);
          if (it.wr)  check_output("mwe_first", g, 32'(f_mwe - it.e0), 32'd2);
          n_mce = 0; n_moe = 0; n_mwe = 0; n_oea = 0; n_oeb = 0;
          f_mce = -1; f_moe = -1; f_mwe = -1; clash = 1'b0;
        end
      end
    end
  end

  task automatic push_item(input int d, input item_t it);
    case (d)
      0:       mon[0].sbq.push_back(it);
      1:       mon[1].sbq.push_back(it);
      default: mon[2].sbq.push_back(it);
    endcase
  endtask

  task automatic check_idle(input int d);
    check_output("idle_strobes", d,
                 32'({mce_l[d], moe_l[d], mwe_l[d], oea_l[d], oeb_l[d]}), 32'h1F);
    check_output("idle_busy", d, 32'(busy[d]), 32'd0);
    check_output("idle_done", d, 32'(done[d]), 32'd0);
    check_output("idle_rdata", d, 32'(rdata_q[d]), 32'd0);
    check_output("idle_maddr", d, 32'(maddr[d]), 32'd0);
    check_output("idle_mdata_out", d, 32'(mdata_out[d]), 32'd0);
  endtask

  // Called one step after a rising edge with the DUT idle; returns in the first
  // idle cycle after RECOVER, the earliest point a new request can be accepted.
  // MDATA_IN carries the real read word only during the last ACCESS cycle.
  task automatic apply_stimulus(input int d, input logic w, input logic [11:0] a,
                                input logic [15:0] wd, input logic [1:0] ln,
                                input logic [15:0] rv, input bit hold);
    item_t it;
    int    n;
    n        = NS[d];
    it.e0    = cyc;
    it.wr    = w;
    it.addr  = a;
    it.wdata = wd;
    it.lane  = ln;
    it.rdata = w ? last_read[d] : rv;
    if (!w) last_read[d] = rv;
    push_item(d, it);
    req[d] = 1'b1; wr[d] = w; addr[d] = a; wdata[d] = wd; lane_en[d] = ln;
    mdata_in[d] = ~rv;
    for (int j = 1; j <= n + 3; j++) begin
      @(posedge clk); #1;
      req[d]      = hold;
      wr[d]       = ~w;
      addr[d]     = a ^ 12'hFFF;
      wdata[d]    = ~wd;
      lane_en[d]  = ~ln;
      mdata_in[d] = (j == n + 1) ? rv : ~rv;
    end
    check_output("end_busy", d, 32'(busy[d]), 32'd0);
    check_output("end_done", d, 32'(done[d]), 32'd0);
  endtask

  task automatic reset_mid_access();
    req[0] = 1'b1; wr[0] = 1'b1; addr[0] = 12'h5C3; wdata[0] = 16'hDEAD; lane_en[0] = 2'b11;
    @(posedge clk); #1;
    req[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int d = 0; d < 3; d++) begin
      check_idle(d);
      last_read[d] = 16'h0000;
    end
    repeat (8) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    for (int d = 0; d < 3; d++) begin
      req[d] = 1'b0; wr[d] = 1'b0; addr[d] = '0; wdata[d] = '0;
      lane_en[d] = 2'b00; mdata_in[d] = '0; last_read[d] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) check_idle(d);

    apply_stimulus(0, 1'b0, 12'h2A5, 16'h5A5A, 2'b00, 16'hBEEF, 1'b0);
    apply_stimulus(0, 1'b1, 12'h3C1, 16'h1234, 2'b10, 16'h0000, 1'b0);
    apply_stimulus(0, 1'b1, 12'h07E, 16'hA1B2, 2'b01, 16'h0000, 1'b0);
    apply_stimulus(0, 1'b1, 12'h100, 16'hC3D4, 2'b00, 16'h0000, 1'b0);

    apply_stimulus(0, 1'b0, 12'h111, 16'hAAAA, 2'b11, 16'hC0DE, 1'b1);
    apply_stimulus(0, 1'b1, 12'h222, 16'h5555, 2'b01, 16'h0000, 1'b1);
    apply_stimulus(0, 1'b0, 12'h333, 16'h0F0F, 2'b10, 16'h7E57, 1'b1);
    apply_stimulus(0, 1'b1, 12'h444, 16'hF00D, 2'b11, 16'h0000, 1'b0);

    reset_mid_access();
    apply_stimulus(0, 1'b0, 12'h155, 16'h0000, 2'b00, 16'h600D, 1'b0);

    apply_stimulus(1, 1'b0, 12'h0AB, 16'h1111, 2'b00, 16'hA5A5, 1'b0);
    apply_stimulus(1, 1'b1, 12'h0CD, 16'h2222, 2'b11, 16'h0000, 1'b1);
    apply_stimulus(1, 1'b0, 12'h0EF, 16'h3333, 2'b10, 16'h3C3C, 1'b0);

    apply_stimulus(2, 1'b1, 12'hFFF, 16'hFFFF, 2'b01, 16'h0000, 1'b0);
    apply_stimulus(2, 1'b0, 12'h800, 16'h8000, 2'b00, 16'h1357, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check_output("pending_txn", 0, 32'(mon[0].sbq.size()), 32'd0);
    check_output("pending_txn", 1, 32'(mon[1].sbq.size()), 32'd0);
    check_output("pending_txn", 2, 32'(mon[2].sbq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
